// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I opcodes, instruction classes and immediate formats
package rv_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Same encoding the main decoder drives on ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_OP     = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_OPIMM  = 3'd4,
    CLS_JAL    = 3'd5
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  function automatic logic [31:0] place_imm(input logic [1:0] fmt, input logic [20:0] imm);
    logic [31:0] w;
    w = '0;
    case (fmt)
      IMM_I: w[31:20] = imm[11:0];
      IMM_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      IMM_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      default: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - combinational RV32I encoder for one instruction description
import rv_isa_pkg::*;

module rv_instr_encoder (
  input  logic [2:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_LOAD:  word = place_imm(IMM_I, imm) | {12'b0, rs1, funct3, rd, OPC_LOAD};
      CLS_OPIMM: word = place_imm(IMM_I, imm) | {12'b0, rs1, funct3, rd, OPC_OPIMM};
      CLS_STORE: word = place_imm(IMM_S, imm) | {7'b0, rs2, rs1, funct3, 5'b0, OPC_STORE};
      CLS_OP:    word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
      CLS_BRANCH: begin
        // Branch and jump targets are halfword aligned; bit 0 cannot be encoded
        illegal = imm[0];
        word    = place_imm(IMM_B, imm) | {7'b0, rs2, rs1, funct3, 5'b0, OPC_BRANCH};
      end
      CLS_JAL: begin
        illegal = imm[0];
        word    = place_imm(IMM_J, imm) | {20'b0, rd, OPC_JAL};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes instruction requests and loads them into instruction memory
import rv_isa_pkg::*;

module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [20:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  load_state_e state, state_nxt;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept, write, restart;
  logic [ADDR_W:0] count_inc;

  rv_instr_encoder u_enc (
    .cls    (in_class),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (enc_word),
    .illegal(enc_illegal)
  );

  assign in_ready  = (state == ST_LOAD) && (count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign write     = accept && !enc_illegal;
  assign restart   = start && (state != ST_LOAD);
  assign count_inc = count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: if (finish || (write && count_inc == DEPTH_C)) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // cpu_hold lags the state by one cycle so the final write lands before the core runs
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      mem_we   <= write;
      cpu_hold <= (state != ST_DONE);
      if (restart) begin
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (write) count <= count_inc;
        if (accept && enc_illegal) err <= 1'b1;
      end
      if (write) begin
        mem_addr  <= ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];
        mem_wdata <= enc_word;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid;
  logic [2:0]  in_class;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [20:0] in_imm;

  logic        d_in_ready, d_mem_we, d_cpu_hold, d_err;
  logic [5:0]  d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [6:0]  d_count;

  logic        s_in_ready, s_mem_we, s_cpu_hold, s_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(d_in_ready), .in_class(in_class),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
    .mem_wdata(d_mem_wdata), .cpu_hold(d_cpu_hold), .count(d_count), .err(d_err)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(1)) u_small (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_class(in_class),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .cpu_hold(s_cpu_hold), .count(s_count), .err(s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [20:0] imm);
    in_valid  = 1'b1;
    in_class  = c;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    tick();
    tick();
    chk("rst_in_ready", d_in_ready, 0);
    chk("rst_mem_we", d_mem_we, 0);
    chk("rst_mem_addr", d_mem_addr, 0);
    chk("rst_mem_wdata", d_mem_wdata, 0);
    chk("rst_cpu_hold", d_cpu_hold, 1);
    chk("rst_count", d_count, 0);
    chk("rst_err", d_err, 0);

    reset = 1'b0;
    tick();
    chk("idle_in_ready", d_in_ready, 0);
    pulse_start();
    chk("load_in_ready", d_in_ready, 1);

    // LOAD lw x5, 8(x1)
    req(3'd0, 5'd5, 5'd1, 5'd0, 3'b010, 7'd0, 21'd8);
    tick();
    in_valid = 1'b0;
    chk("lw_we", d_mem_we, 1);
    chk("lw_addr", d_mem_addr, 0);
    chk("lw_wdata", d_mem_wdata, 32'h0080A283);
    chk("lw_count", d_count, 1);
    tick();
    chk("lw_we_drop", d_mem_we, 0);

    pulse_finish();
    chk("fin_in_ready", d_in_ready, 0);
    tick();
    chk("fin_cpu_hold", d_cpu_hold, 0);
    pulse_start();
    chk("restart_count", d_count, 0);

    // add x3,x1,x2 then jal x1,8 back to back
    req(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
    tick();
    chk("add_we", d_mem_we, 1);
    chk("add_addr", d_mem_addr, 0);
    chk("add_wdata", d_mem_wdata, 32'h002081B3);
    req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd8);
    tick();
    chk("jal_we", d_mem_we, 1);
    chk("jal_addr", d_mem_addr, 1);
    chk("jal_wdata", d_mem_wdata, 32'h008000EF);
    chk("jal_count", d_count, 2);

    // beq x0,x0,8 then a misaligned branch
    req(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd8);
    tick();
    chk("beq_wdata", d_mem_wdata, 32'h00000463);
    chk("beq_addr", d_mem_addr, 2);
    chk("beq_err", d_err, 0);
    req(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd5);
    tick();
    in_valid = 1'b0;
    chk("bmis_we", d_mem_we, 0);
    chk("bmis_err", d_err, 1);
    chk("bmis_count", d_count, 3);

    pulse_finish();
    chk("err_sticky", d_err, 1);
    pulse_start();
    chk("start_err_clr", d_err, 0);
    chk("start_count_clr", d_count, 0);

    // illegal class
    req(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 21'd0);
    tick();
    in_valid = 1'b0;
    chk("cls6_we", d_mem_we, 0);
    chk("cls6_err", d_err, 1);
    chk("cls6_count", d_count, 0);
    pulse_finish();
    pulse_start();
    chk("cls6_restart_err", d_err, 0);
    chk("cls6_restart_count", d_count, 0);

    // sw x2, 12(x1): S-format split immediate
    req(3'd1, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 21'd12);
    tick();
    chk("sw_wdata", d_mem_wdata, 32'h0020A623);

    // finish together with an accepted request
    req(3'd0, 5'd5, 5'd1, 5'd0, 3'b010, 7'd0, 21'd8);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    in_valid = 1'b0;
    chk("finreq_we", d_mem_we, 1);
    chk("finreq_addr", d_mem_addr, 1);
    chk("finreq_wdata", d_mem_wdata, 32'h0080A283);
    chk("finreq_in_ready", d_in_ready, 0);
    chk("finreq_hold_still", d_cpu_hold, 1);
    tick();
    chk("finreq_hold_fall", d_cpu_hold, 0);

    // reset while loading with a valid request
    pulse_start();
    req(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
    reset = 1'b1;
    tick();
    chk("midrst_we", d_mem_we, 0);
    chk("midrst_count", d_count, 0);
    chk("midrst_hold", d_cpu_hold, 1);
    chk("midrst_ready", d_in_ready, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    tick();

    // small instance: fill all four words, pointer wraps from base 1
    pulse_start();
    req(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);
    tick();
    chk("s_first_addr", s_mem_addr, 1);
    tick();
    tick();
    chk("s_third_addr", s_mem_addr, 3);
    chk("s_ready_before_full", s_in_ready, 1);
    tick();
    chk("s_last_we", s_mem_we, 1);
    chk("s_last_addr_wrap", s_mem_addr, 0);
    chk("s_full_count", s_count, 4);
    chk("s_full_ready", s_in_ready, 0);
    chk("s_full_hold", s_cpu_hold, 1);
    tick();
    in_valid = 1'b0;
    chk("s_fifth_we", s_mem_we, 0);
    chk("s_fifth_count", s_count, 4);
    chk("s_hold_fall", s_cpu_hold, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the main control decoder.
- Accepts instruction descriptions (class plus fields), encodes each into a 32-bit RV32I word using the same I/S/B/J immediate formats the decoder selects with ImmSrc, and writes the words sequentially into instruction memory.
- Holds the single-cycle core in reset via cpu_hold while a program is loaded.

Parameters:
- ADDR_W, 6, word-address width; capacity DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: clear write pointer, begin loading.
- finish  in  1  pulse: end of program.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_class  in  3  0 LOAD, 1 STORE, 2 OP, 3 BRANCH, 4 OPIMM, 5 JAL, 6-7 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field.
- in_imm  in  21  signed immediate, byte offset.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- cpu_hold  out  1  high while not DONE.
- count  out  ADDR_W+1  words written since start.
- err  out  1  sticky: a request was rejected.

Behaviour:
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, count 0, err 0.
- Reset mid-operation: any pending write is dropped; reset values apply from the next edge.
- FSM states IDLE, LOAD, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> DONE on finish, or when count reaches DEPTH.
  - DONE -> LOAD on start (restart: pointer, count and err cleared).
  - start during LOAD is ignored.
- in_ready = (state == LOAD) && (count < DEPTH).
- Throughput: one accepted request per cycle.
- Latency: a request accepted at edge N drives mem_we=1, mem_addr, mem_wdata for exactly the cycle after edge N (registered output).
- mem_addr = BASE_ADDR + count, modulo 2**ADDR_W. count increments on each write.
- Opcodes: LOAD 0000011, STORE 0100011, OP 0110011, BRANCH 1100011, OPIMM 0010011, JAL 1101111.
- Field placement:
  - rd -> [11:7], funct3 -> [14:12], rs1 -> [19:15], rs2 -> [24:20], funct7 -> [31:25].
  - Fields a format does not carry are forced to 0.
- Immediate formats:
  - I (LOAD, OPIMM): imm[11:0] -> [31:20].
  - S: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - B: imm[12] -> 31, imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> 7.
  - J: imm[20] -> 31, imm[10:1] -> [30:21], imm[11] -> 20, imm[19:12] -> [19:12].
- Rejection: an illegal class, or BRANCH/JAL with imm[0]=1.
  - The handshake completes, no write occurs, count is unchanged, and err is set until reset or start.
- finish and an accepted request in the same cycle: the word is written on the following cycle, and state becomes DONE at the same edge the request is accepted.
- Full: at count == DEPTH the FSM enters DONE and in_ready is 0.
- cpu_hold = (state != DONE); it deasserts the cycle after entry to DONE, after the final write.

Decomposition:
- Package rv_isa_pkg holds:
  - opcode localparams (shared with the main decoder);
  - instruction-class enum;
  - immediate-format constants IMM_I/S/B/J = 00/01/10/11, matching ImmSrc.
- One combinational sub-module, rv_instr_encoder: class and fields in, 32-bit word and illegal flag out.
- FSM, pointer and output registers stay in the top.

Test Plan:
- reset, start, then LOAD rd=5 rs1=1 f3=010 imm=8 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x0080A283; count=1.
- OP add rd=3 rs1=1 rs2=2 f3=0 f7=0, then JAL rd=1 imm=8, back-to-back -> 0x002081B3 @ addr 0, then 0x008000EF @ addr 1, on consecutive cycles.
- BRANCH rs1=0 rs2=0 f3=0 imm=8 -> 0x00000463; then BRANCH imm=5 -> no write, err=1, count unchanged.
- class=6 accepted -> no write, err=1; a subsequent start -> err=0, count=0.
- ADDR_W=2: four writes -> DONE after the 4th accept, in_ready=0, cpu_hold falls one cycle after the last write; a 5th valid is not accepted.
- finish together with a valid request -> that word is still written and the FSM is in DONE; reset asserted during LOAD with in_valid high -> mem_we=0, count=0, cpu_hold=1 on the next cycle.
